// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// A fetch_entry_t is one fetched instruction travelling toward decode.
package fetch_pkg;

  localparam int          INS_W      = 32;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef struct packed {
    logic [INS_W-1:0] instr;
    logic [INS_W-1:0] pc;
    logic             is_branch;
    logic             pred_taken;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries between fetch and decode.
// Flush empties it in one edge and wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  fetch_entry_t  mem [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch requester: owns the PC, drives instruction memory and queues
// fetched instructions toward decode; execute-stage redirects flush the queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  ins_size = 32,
  parameter logic [ins_size-1:0] RESET_PC = 32'h0000_0000,
  parameter int                  FQ_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ins_size-1:0] pc_out,
  input  logic [ins_size-1:0] instruction_in,
  input  logic                branch_check_in,
  input  logic [ins_size-1:0] imm_yags_in,
  input  logic                pred_taken_in,
  input  logic                redirect_valid,
  input  logic [ins_size-1:0] redirect_pc,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [ins_size-1:0] dec_instr,
  output logic [ins_size-1:0] dec_pc,
  output logic                dec_is_branch,
  output logic                dec_pred_taken
);

  logic [ins_size-1:0] pc, pc_next, target;
  logic                full, empty, fetch_en, pop;
  fetch_entry_t        wr_entry, head;

  assign pc_out    = pc;
  assign dec_valid = !empty;
  assign pop       = dec_valid && dec_ready && !redirect_valid;
  assign fetch_en  = !redirect_valid && (!full || (dec_valid && dec_ready));
  assign target    = (pc + imm_yags_in) & ~ins_size'(3);

  assign wr_entry.instr      = instruction_in;
  assign wr_entry.pc         = pc;
  assign wr_entry.is_branch  = branch_check_in;
  assign wr_entry.pred_taken = branch_check_in & pred_taken_in;

  // Redirect beats prediction; a stalled fetch keeps re-reading the same word.
  always_comb begin
    pc_next = pc;
    if (redirect_valid)
      pc_next = redirect_pc & ~ins_size'(3);
    else if (fetch_en && branch_check_in && pred_taken_in)
      pc_next = target;
    else if (fetch_en)
      pc_next = pc + ins_size'(PC_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (fetch_en),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  // Head fields read as zero whenever nothing is waiting for decode.
  assign dec_instr      = dec_valid ? head.instr      : '0;
  assign dec_pc         = dec_valid ? head.pc         : '0;
  assign dec_is_branch  = dec_valid ? head.is_branch  : 1'b0;
  assign dec_pred_taken = dec_valid ? head.pred_taken : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural fetch model queues the
// expected decode stream, a negedge monitor pops and compares it.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out, instruction_in, imm_yags_in, redirect_pc;
  logic        branch_check_in, pred_taken_in, redirect_valid;
  logic        dec_valid, dec_ready, dec_is_branch, dec_pred_taken;
  logic [31:0] dec_instr, dec_pc;

  logic [31:0] mem_instr [256];
  logic [31:0] mem_imm   [256];
  logic        mem_br    [256];
  logic        mem_pd    [256];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br;
    logic        pd;
  } exp_t;

  exp_t        exp_q [$];
  logic        exp_valid = 1'b0;
  logic [31:0] cur_pc = '0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign instruction_in  = mem_instr[pc_out[9:2]];
  assign branch_check_in = mem_br[pc_out[9:2]];
  assign imm_yags_in     = mem_imm[pc_out[9:2]];
  assign pred_taken_in   = mem_pd[pc_out[9:2]];

  fetch_unit #(.ins_size(32), .RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_out          (pc_out),
    .instruction_in  (instruction_in),
    .branch_check_in (branch_check_in),
    .imm_yags_in     (imm_yags_in),
    .pred_taken_in   (pred_taken_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_is_branch   (dec_is_branch),
    .dec_pred_taken  (dec_pred_taken)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fillMemory(input bit with_branches);
    for (int i = 0; i < 256; i++) begin
      logic is_br;
      int   off;
      is_br        = with_branches && ($urandom_range(0, 3) == 0);
      off          = (int'($urandom_range(0, 63)) - 32) * 2;
      mem_br[i]    = is_br;
      mem_pd[i]    = 1'($urandom_range(0, 1));
      mem_imm[i]   = 32'(off);
      mem_instr[i] = {$urandom(), 7'b0} | {25'b0, (is_br ? 7'b1100011 : 7'b0010011)};
    end
  endtask

  task automatic doReset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    exp_q.delete();
    exp_valid      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    cur_pc = RESET_PC;
  endtask

  // Reference model: one call covers one clock cycle of fetch behaviour.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    int          pre;
    logic        popping, fetch;
    logic [31:0] next_pc;
    int          idx;
    exp_t        e;
    dec_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    idx       = int'(cur_pc[9:2]);
    pre       = exp_q.size();
    exp_valid = (pre > 0);
    popping   = exp_valid && rdy;
    fetch     = !redir && (pre < FQ_DEPTH || popping);
    next_pc   = cur_pc;
    if (redir) begin
      exp_q.delete();
      next_pc = {rpc[31:2], 2'b00};
    end else if (fetch) begin
      e.instr = mem_instr[idx];
      e.pc    = cur_pc;
      e.br    = mem_br[idx];
      e.pd    = mem_br[idx] && mem_pd[idx];
      exp_q.push_back(e);
      if (e.pd) next_pc = (cur_pc + mem_imm[idx]) & 32'hFFFF_FFFC;
      else      next_pc = cur_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cur_pc = next_pc;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("pc_out", pc_out, cur_pc);
      checkOutput("dec_valid", {31'b0, dec_valid}, {31'b0, exp_valid});
      if (exp_valid && !redirect_valid && exp_q.size() > 0) begin
        checkOutput("dec_pc", dec_pc, exp_q[0].pc);
        checkOutput("dec_instr", dec_instr, exp_q[0].instr);
        checkOutput("dec_is_branch", {31'b0, dec_is_branch}, {31'b0, exp_q[0].br});
        checkOutput("dec_pred_taken", {31'b0, dec_pred_taken}, {31'b0, exp_q[0].pd});
        if (dec_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    fillMemory(1'b0);
    #1;
    checkOutput("reset_pc_out", pc_out, RESET_PC);
    checkOutput("reset_dec_valid", {31'b0, dec_valid}, 32'd0);
    checkOutput("reset_dec_pc", dec_pc, 32'd0);
    checkOutput("reset_dec_instr", dec_instr, 32'd0);

    // Straight-line fetch of non-branches
    doReset();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("seq_pc_out", pc_out, 32'(4 * i));
    end

    // Predicted-taken branch at PC 8, forward then backward
    mem_br[2] = 1'b1; mem_pd[2] = 1'b1; mem_imm[2] = 32'h10;
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("fwd_target", pc_out, 32'h18);
    checkOutput("fwd_head_pc", dec_pc, 32'h8);
    checkOutput("fwd_head_br", {31'b0, dec_is_branch}, 32'd1);
    checkOutput("fwd_head_pd", {31'b0, dec_pred_taken}, 32'd1);
    mem_imm[2] = 32'hFFFF_FFF8;
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("bwd_target", pc_out, 32'h0);
    repeat (4) applyStimulus(1'b1, 1'b0, '0);
    fillMemory(1'b0);

    // Decode stall fills the queue, then drains without gaps
    doReset();
    repeat (5) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("stall_pc_hold", pc_out, 32'h8);
    checkOutput("stall_head", dec_pc, 32'h0);
    repeat (5) applyStimulus(1'b1, 1'b0, '0);

    // Redirect with a full queue, misaligned target
    doReset();
    repeat (4) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 32'h103);
    checkOutput("redir_pc", pc_out, 32'h100);
    checkOutput("redir_flush", {31'b0, dec_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("redir_first", dec_pc, 32'h100);

    // PC wraps from the top of the address space
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("wrap_pc", pc_out, 32'h0);
    applyStimulus(1'b1, 1'b0, '0);

    // Async reset in the middle of a full stall
    repeat (4) applyStimulus(1'b0, 1'b0, '0);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_valid", {31'b0, dec_valid}, 32'd0);
    checkOutput("midrst_pc", pc_out, RESET_PC);
    checkOutput("midrst_dec_pc", dec_pc, 32'd0);

    // Randomized traffic with branches, stalls and redirects
    fillMemory(1'b1);
    doReset();
    for (int i = 0; i < 600; i++) begin
      logic        rdy, redir;
      logic [31:0] rpc;
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      applyStimulus(rdy, redir, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Requester side of the instruction-memory fetch interface.
- Owns the architectural PC, drives it to the combinational instruction memory each cycle, and captures the returned instruction, branch flag and B-type immediate.
- Forms the next PC from the YAGS prediction, or from an execute-stage redirect on mispredict.
- Buffers fetched instructions in a small queue toward decode with a valid/ready handshake.

Parameters:
- ins_size, 32, PC/instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FQ_DEPTH, 2, fetch-queue entries (power of two, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_out  out  ins_size  fetch address to instruction memory (PC_in).
- instruction_in  in  ins_size  instruction word returned combinationally for pc_out.
- branch_check_in  in  1  instruction_in is a conditional branch (opcode 7'b1100011).
- imm_yags_in  in  ins_size  sign-extended B-type offset of instruction_in.
- pred_taken_in  in  1  YAGS prediction for pc_out, combinational, same cycle.
- redirect_valid  in  1  execute-stage mispredict/jump correction.
- redirect_pc  in  ins_size  corrected target.
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decode accepts head.
- dec_instr  out  ins_size  head instruction.
- dec_pc  out  ins_size  head PC.
- dec_is_branch  out  1  head branch_check.
- dec_pred_taken  out  1  head prediction; forced 0 when head is not a branch.

Behaviour:
- Reset (async, while rst=1):
  - pc = RESET_PC; queue empty; dec_valid = 0.
  - dec_instr, dec_pc = 0; dec_is_branch, dec_pred_taken = 0.
  - pc_out follows pc, so it is RESET_PC during reset.
- pc_out is the PC register output directly; no combinational path from any input to pc_out.
- Fetch enable: fetch_en = !redirect_valid && (!full || (dec_valid && dec_ready)).
- Push when fetch_en. Entry = {instruction_in, pc, branch_check_in, branch_check_in & pred_taken_in}.
- Next PC, in priority order:
  1. redirect_valid: redirect_pc & ~32'h3.
  2. fetch_en && branch_check_in && pred_taken_in: pc + imm_yags_in.
  3. fetch_en: pc + 4.
  4. Otherwise: pc held.
- PC arithmetic is modulo 2^ins_size; wrap from 32'hFFFF_FFFC to 0 is legal. A predicted target's low 2 bits are forced to 0.
- Pop when dec_valid && dec_ready.
- Push and pop in the same cycle when full is allowed: occupancy unchanged.
- Push when empty: the entry is visible on dec_* the next cycle. Fetch-to-decode latency is 1 cycle; there is no bypass.
- Redirect:
  - Flushes every queue entry in the same edge; no push that cycle.
  - dec_valid = 0 the following cycle.
  - The first instruction from redirect_pc appears on dec_* two cycles after the redirect cycle.
  - A redirect while dec_valid && dec_ready is still a flush; the pop is ignored.
- Full and not popping: PC held and no push. The instruction memory keeps presenting the same word, so nothing is lost.
- Queue read/write pointers wrap modulo FQ_DEPTH. A count field of log2(FQ_DEPTH)+1 bits distinguishes full from empty.
- Reset asserted mid-operation discards the queue and any pending redirect. Fetch restarts at RESET_PC on the first edge after rst falls.
- Instruction memory decodes pc[21:2]. The unit does not range-check; addresses alias above 4 MiB.

Decomposition:
- Shared package fetch_pkg:
  - Constants: OPC_BRANCH = 7'b1100011, PC_STEP = 4.
  - typedef struct fetch_entry_t {instr, pc, is_branch, pred_taken}.
- Sub-module fetch_queue: parameterised synchronous FIFO of fetch_entry_t with push, pop and flush, exposing full, empty and head.
- fetch_unit holds the PC register, next-PC mux and handshake logic.

Test Plan:
- Reset, dec_ready=1, memory of non-branches: pc_out = 0, 4, 8, 12 on consecutive cycles; dec_pc = 0, 4, 8 starting one cycle after the first fetch.
- Branch at PC 8 with imm = 32'h10, pred_taken_in=1: next pc_out = 32'h18; the entry for PC 8 has dec_is_branch=1, dec_pred_taken=1. Repeat with imm = 32'hFFFF_FFF8: next pc_out = 0.
- dec_ready=0 for 5 cycles: queue fills to 2 (PCs 0, 4); pc_out holds 8. Raise dec_ready: dec_pc = 0, 4, 8 with no gaps and no duplicates.
- Queue full, redirect_valid=1, redirect_pc = 32'h103: next cycle pc_out = 32'h100 and dec_valid = 0; the following cycle dec_pc = 32'h100.
- pc = 32'hFFFF_FFFC, non-branch: next pc_out = 0. Assert rst mid-stall with a full queue: dec_valid drops immediately and pc_out = RESET_PC.
